lfsr_burst_ctrl: RTL and testbench
==================================

// Module: lfsr_burst_ctrl
// PURPOSE
//  Sequences and shares one internal W-bit Fibonacci LFSR between two requesters.
//  A requester asks for a burst of LEN pseudo-random words.
//  A round-robin arbiter grants one burst at a time, and the controller streams the words over a valid/ready port.
//  A seed-load path reconfigures the LFSR between bursts.
// PARAMETERS
//  W     3       LFSR/data width (>=2)
//  TAPS  3'b101  feedback tap mask; fb = ^(state & TAPS)
//  SEED  3'b100  reset/reload value of LFSR state
//  LW    4       burst-length field width
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   synchronous reset, active-high
//  REQ0/REQ1  in   1   burst request, held until granted
//  LEN0/LEN1  in   LW  burst length for the corresponding requester; 0 means 2^LW words
//  GNT0/GNT1  out  1   one-cycle grant pulse
//  SEED_WE    in   1   load SEED_IN into LFSR state
//  SEED_IN    in   W   new seed
//  OUT_VALID  out  1   OUT_DATA valid
//  OUT_READY  in   1   consumer accepts word
//  OUT_DATA   out  W   current LFSR state
//  OUT_ID     out  1   requester owning current burst
//  OUT_LAST   out  1   final word of burst
//  BUSY       out  1   burst in progress (FSM in RUN)
// BEHAVIOUR
//  - Reset (RST high at edge):
//    - FSM=IDLE; LFSR state=SEED; count=0; rr pointer = requester 0 has priority.
//    - All outputs 0. OUT_DATA is the registered LFSR state, so it reads SEED after reset.
//  - LFSR step: state <= {^(state&TAPS), state[W-1:1]}.
//    - Steps only on OUT_VALID&OUT_READY; otherwise state is held.
//  - FSM IDLE:
//    - If SEED_WE: state<=SEED_IN this edge. This has priority over arbitration in the same cycle, and the request is then granted next cycle.
//    - Else if REQ0|REQ1: winner is picked by round-robin (the requester not granted last wins a tie; a single request wins outright).
//    - Next cycle: GNTx=1 for exactly one cycle, OUT_ID=x, count=LEN (0->2^LW), FSM=RUN.
//  - FSM RUN:
//    - OUT_VALID=1 and BUSY=1. OUT_DATA, OUT_ID and OUT_LAST hold stable while OUT_READY=0.
//    - OUT_LAST=1 when count==1.
//    - On accept: LFSR steps and count decrements. If the accepted word had OUT_LAST: FSM=IDLE and the rr pointer records the winner.
//    - Back-to-back bursts therefore have a one-cycle bubble (IDLE).
//  - Request rules:
//    - REQ seen high during GNT or RUN is ignored. The requester drops REQ on GNT.
//    - LEN is sampled only in the arbitration cycle.
//  - SEED_WE during RUN is ignored (no effect, no error).
//  - LFSR state persists across bursts; a burst continues the sequence of the previous one.
//  - RST mid-burst: aborts immediately, no OUT_LAST, state returns to SEED.
//  - Latency: REQ high in IDLE at edge n -> GNT and first OUT_VALID in cycle n+1.
// CONFIGURATION
//  LFSR_CTRL_ZERO_GUARD_EN defined:
//    - A SEED_IN of all-zero loads SEED instead.
//    - If the state is ever all-zero, the next update loads SEED.
//  Not defined:
//    - Zero seed loads as-is; the LFSR locks at 0 and OUT_DATA stays 0 for all bursts.
// TESTING
//  - Reset, REQ0=1 LEN0=7 (W=3 defaults), READY=1:
//    - GNT0 pulse, then OUT_DATA 100,110,111,011,101,010,001.
//    - OUT_LAST on 001, then IDLE.
//  - REQ0 and REQ1 both held:
//    - Grants alternate 0,1,0.
//    - Each later burst continues the sequence; bubble of 1 cycle between bursts.
//  - OUT_READY toggled 1,0,0,1 during LEN=2 burst:
//    - Data/LAST held while stalled; exactly 2 words accepted.
//  - SEED_WE=1 SEED_IN=011 in IDLE, LEN=0 burst:
//    - 16 words starting 011; SEED_WE during RUN is ignored.
//  - RST asserted mid-burst:
//    - Next cycle all outputs 0, OUT_DATA=100, no OUT_LAST.
//    - New REQ is served normally.
//  - SEED_IN=000:
//    - With LFSR_CTRL_ZERO_GUARD_EN, first word is 100.
//    - Without it, all words are 000.

Source files
------------

// File: rtl/lfsr_burst_ctrl.sv
// Two-requester burst controller sharing one Fibonacci LFSR, streamed over valid/ready.
// Optional build macro LFSR_CTRL_ZERO_GUARD_EN keeps the LFSR out of the all-zero lock-up state.
module lfsr_burst_ctrl #(
  parameter int unsigned    W    = 3,
  parameter logic [W-1:0]   TAPS = 3'b101,
  parameter logic [W-1:0]   SEED = 3'b100,
  parameter int unsigned    LW   = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic [LW-1:0] LEN0,
  input  logic [LW-1:0] LEN1,
  output logic          GNT0,
  output logic          GNT1,
  input  logic          SEED_WE,
  input  logic [W-1:0]  SEED_IN,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [W-1:0]  OUT_DATA,
  output logic          OUT_ID,
  output logic          OUT_LAST,
  output logic          BUSY
);

  // One extra bit so a zero length field can encode 2^LW words
  localparam int unsigned CW = LW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    lfsr_q, lfsr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rr_last_q, rr_last_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            out_valid_q, out_valid_d;
  logic            out_id_q, out_id_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;

  logic            fb_c;
  logic [W-1:0]    lfsr_step_c;
  logic [W-1:0]    seed_load_c;
  logic            win_id_c;
  logic [LW-1:0]   win_len_c;
  logic [CW-1:0]   burst_len_c;
  logic            arb_go_c;
  logic            accept_c;

  // LFSR next value and seed-load value, with optional zero-state guard
  always_comb begin
    fb_c = ^(lfsr_q & TAPS);
`ifdef LFSR_CTRL_ZERO_GUARD_EN
    lfsr_step_c = (lfsr_q == '0) ? SEED : {fb_c, lfsr_q[W-1:1]};
    seed_load_c = (SEED_IN == '0) ? SEED : SEED_IN;
`else
    lfsr_step_c = {fb_c, lfsr_q[W-1:1]};
    seed_load_c = SEED_IN;
`endif
  end

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    win_id_c    = (REQ0 && REQ1) ? ~rr_last_q : REQ1;
    win_len_c   = win_id_c ? LEN1 : LEN0;
    burst_len_c = (win_len_c == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, win_len_c};
    arb_go_c    = (REQ0 | REQ1) & ~SEED_WE;
    accept_c    = out_valid_q & OUT_READY;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_go_c) state_d = ST_RUN;
      ST_RUN:  if (accept_c && out_last_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    lfsr_d      = lfsr_q;
    count_d     = count_q;
    rr_last_d   = rr_last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        out_last_d  = 1'b0;
        if (SEED_WE) begin
          lfsr_d = seed_load_c;
        end else if (REQ0 || REQ1) begin
          gnt0_d      = ~win_id_c;
          gnt1_d      = win_id_c;
          out_id_d    = win_id_c;
          count_d     = burst_len_c;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          out_last_d  = (burst_len_c == CW'(1));
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          lfsr_d  = lfsr_step_c;
          count_d = count_q - CW'(1);
          if (out_last_q) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            out_last_d  = 1'b0;
            rr_last_d   = out_id_q;
          end else begin
            out_last_d = (count_q == CW'(2));
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q      <= SEED;
      count_q     <= '0;
      rr_last_q   <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      count_q     <= count_d;
      rr_last_q   <= rr_last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = lfsr_q;
  assign OUT_ID    = out_id_q;
  assign OUT_LAST  = out_last_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl: scenario tasks checked against a transaction-level LFSR/arbiter model.
module tb_lfsr_burst_ctrl;

  localparam int unsigned  W    = 3;
  localparam int unsigned  LW   = 4;
  localparam logic [W-1:0] TAPS = 3'b101;
  localparam logic [W-1:0] SEED = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [LW-1:0] len0 = '0, len1 = '0;
  logic          gnt0, gnt1;
  logic          seed_we = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_id, out_last, busy;

  always #5 clk = ~clk;

  lfsr_burst_ctrl #(.W(W), .TAPS(TAPS), .SEED(SEED), .LW(LW)) dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .LEN0(len0), .LEN1(len1),
    .GNT0(gnt0), .GNT1(gnt1), .SEED_WE(seed_we), .SEED_IN(seed_in),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .OUT_ID(out_id), .OUT_LAST(out_last), .BUSY(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current LFSR value and id of the last completed burst
  logic [W-1:0] m_state;
  logic         m_last;
  logic [W-1:0] exp_data[$];

  // Observations from one burst
  logic [W-1:0] obs_data[$];
  logic         obs_last[$];
  logic         obs_id[$];
  int           obs_gid;
  int           obs_gnt_wait;
  int           obs_hold_err;
  int           obs_proto_err;
  bit           obs_timeout;
  int           ready_mode = 0;
  logic         ready_pat[$];

  function automatic logic [W-1:0] model_next(input logic [W-1:0] s);
    int fb;
`ifdef LFSR_CTRL_ZERO_GUARD_EN
    if (s == '0) return SEED;
`endif
    fb = $countones(s & TAPS) % 2;
    return W'((fb << (W - 1)) | (int'(s) >> 1));
  endfunction

  function automatic logic [W-1:0] model_seed(input logic [W-1:0] v);
`ifdef LFSR_CTRL_ZERO_GUARD_EN
    if (v == '0) return SEED;
`endif
    return v;
  endfunction

  function automatic int model_len(input logic [LW-1:0] l);
    return (l == '0) ? (1 << LW) : int'(l);
  endfunction

  function automatic logic model_winner(input logic r0, input logic r1);
    if (r0 && r1) return ~m_last;
    return r1;
  endfunction

  task automatic model_burst(input int n);
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(m_state);
      m_state = model_next(m_state);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant, then drives OUT_READY and records every accepted word
  task automatic collect();
    obs_data.delete(); obs_last.delete(); obs_id.delete();
    obs_timeout = 0; obs_hold_err = 0; obs_proto_err = 0; obs_gid = -1;
    obs_gnt_wait = 0;
    while (!(gnt0 | gnt1) && obs_gnt_wait < 8) begin
      tick();
      obs_gnt_wait++;
    end
    if (!(gnt0 | gnt1)) begin
      obs_timeout = 1;
      return;
    end
    obs_gid = gnt1 ? 1 : 0;
    if (gnt0 && gnt1) obs_proto_err++;
    if (gnt0) req0 = 1'b0;
    if (gnt1) req1 = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic         pv, pr, pl, pid;
      logic [W-1:0] pd;
      if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
      else if (ready_mode == 0) out_ready = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
      if (obs_gid == 0) len0 = LW'($urandom);
      else len1 = LW'($urandom);
      pv = out_valid; pr = out_ready; pl = out_last; pid = out_id; pd = out_data;
      if (busy !== out_valid) obs_proto_err++;
      if (cyc > 0 && (gnt0 || gnt1)) obs_proto_err++;
      tick();
      if (pv && pr) begin
        obs_data.push_back(pd);
        obs_last.push_back(pl);
        obs_id.push_back(pid);
        if (pl) begin
          out_ready = 1'b0;
          return;
        end
      end else if (pv) begin
        if (out_data !== pd || out_last !== pl || out_id !== pid) obs_hold_err++;
      end else begin
        obs_proto_err++;
      end
    end
    obs_timeout = 1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; seed_we = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    m_state = SEED;
    m_last  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({gnt0, gnt1, out_valid, out_last, busy, out_id} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 000000", {gnt0, gnt1, out_valid, out_last, busy, out_id});
    end
    n_cmp++;
    if (out_data !== SEED) begin
      n_bad++;
      $display("FAIL reset_data: got %b expected %b", out_data, SEED);
    end
    rst = 1'b0;
    m_state = SEED;
    m_last  = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] golden[7];
    golden = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b101, 3'b010, 3'b001};
    ready_mode = 0;
    req0 = 1'b1; len0 = 4'd7;
    model_burst(7);
    collect();
    n_cmp++;
    if (obs_timeout || obs_gid !== 0 || obs_gnt_wait !== 1 || obs_proto_err !== 0) begin
      n_bad++;
      $display("FAIL basic_grant: got gid=%0d wait=%0d proto=%0d to=%0d expected gid=0 wait=1 proto=0 to=0",
               obs_gid, obs_gnt_wait, obs_proto_err, obs_timeout);
    end
    n_cmp++;
    if (obs_data.size() !== 7) begin
      n_bad++;
      $display("FAIL basic_count: got %0d words expected 7", obs_data.size());
    end
    for (int i = 0; i < 7 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== golden[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 6) || obs_id[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_word%0d: got data=%b last=%b id=%b expected data=%b last=%b id=0",
                 i, obs_data[i], obs_last[i], obs_id[i], golden[i], (i == 6));
      end
    end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    m_last = 1'b0;
  endtask

  task automatic test_alternate();
    logic exp_seq[3];
    exp_seq = '{1'b0, 1'b1, 1'b0};
    do_reset();
    ready_mode = 0;
    len0 = 4'd3; len1 = 4'd2;
    for (int k = 0; k < 3; k++) begin
      logic g;
      int   n;
      req0 = 1'b1; req1 = 1'b1;
      len0 = 4'd3; len1 = 4'd2;
      g = model_winner(1'b1, 1'b1);
      n = g ? 2 : 3;
      model_burst(n);
      collect();
      n_cmp++;
      if (obs_timeout || obs_gid !== int'(exp_seq[k]) || obs_gid !== int'(g) || obs_gnt_wait !== 1) begin
        n_bad++;
        $display("FAIL alt_grant%0d: got gid=%0d wait=%0d expected gid=%0d wait=1", k, obs_gid, obs_gnt_wait, exp_seq[k]);
      end
      n_cmp++;
      if (obs_data.size() !== n || obs_hold_err !== 0 || obs_proto_err !== 0) begin
        n_bad++;
        $display("FAIL alt_count%0d: got %0d words expected %0d", k, obs_data.size(), n);
      end
      for (int i = 0; i < n && i < obs_data.size(); i++) begin
        n_cmp++;
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == n - 1) || obs_id[i] !== g) begin
          n_bad++;
          $display("FAIL alt%0d_word%0d: got data=%b last=%b id=%b expected data=%b last=%b id=%b",
                   k, i, obs_data[i], obs_last[i], obs_id[i], exp_data[i], (i == n - 1), g);
        end
      end
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL alt_bubble%0d: got valid=%b busy=%b expected 0 0", k, out_valid, busy);
      end
      m_last = g;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_stall();
    ready_pat.delete();
    ready_pat.push_back(1'b1); ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0); ready_pat.push_back(1'b1);
    req0 = 1'b1; len0 = 4'd2;
    model_burst(2);
    collect();
    ready_pat.delete();
    n_cmp++;
    if (obs_timeout || obs_gid !== int'(model_winner(1'b1, 1'b0)) || obs_hold_err !== 0 || obs_proto_err !== 0) begin
      n_bad++;
      $display("FAIL stall_hold: got gid=%0d hold_err=%0d proto=%0d expected gid=0 0 0", obs_gid, obs_hold_err, obs_proto_err);
    end
    n_cmp++;
    if (obs_data.size() !== 2) begin
      n_bad++;
      $display("FAIL stall_count: got %0d words expected 2", obs_data.size());
    end
    for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 1)) begin
        n_bad++;
        $display("FAIL stall_word%0d: got data=%b last=%b expected data=%b last=%b", i, obs_data[i], obs_last[i], exp_data[i], (i == 1));
      end
    end
    m_last = 1'b0;
  endtask

  task automatic test_seed();
    ready_mode = 1;
    seed_we = 1'b1; seed_in = 3'b011;
    req0 = 1'b1; len0 = 4'd0;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b0 || out_valid !== 1'b0 || out_data !== 3'b011) begin
      n_bad++;
      $display("FAIL seed_load: got gnt0=%b valid=%b data=%b expected 0 0 011", gnt0, out_valid, out_data);
    end
    m_state = model_seed(3'b011);
    seed_we = 1'b0;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_bad++;
      $display("FAIL seed_grant: got gnt0=%b expected 1", gnt0);
    end
    seed_we = 1'b1; seed_in = 3'b110;
    model_burst(16);
    collect();
    seed_we = 1'b0;
    n_cmp++;
    if (obs_timeout || obs_gid !== 0 || obs_gnt_wait !== 0 || obs_data.size() !== 16 || obs_proto_err !== 0 || obs_hold_err !== 0) begin
      n_bad++;
      $display("FAIL seed_burst: got gid=%0d wait=%0d words=%0d expected gid=0 wait=0 words=16", obs_gid, obs_gnt_wait, obs_data.size());
    end
    for (int i = 0; i < 16 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 15)) begin
        n_bad++;
        $display("FAIL seed_word%0d: got data=%b last=%b expected data=%b last=%b", i, obs_data[i], obs_last[i], exp_data[i], (i == 15));
      end
    end
    m_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    req1 = 1'b1; len1 = 4'd7;
    tick();
    n_cmp++;
    if (gnt1 !== 1'b1 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_grant: got gnt1=%b valid=%b expected 1 1", gnt1, out_valid);
    end
    req1 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, out_valid, out_last, busy, out_id} !== 6'b0 || out_data !== SEED) begin
      n_bad++;
      $display("FAIL rstmid_abort: got flags=%b data=%b expected flags=000000 data=%b",
               {gnt0, gnt1, out_valid, out_last, busy, out_id}, out_data, SEED);
    end
    rst = 1'b0; out_ready = 1'b0;
    m_state = SEED; m_last = 1'b1;
    ready_mode = 1;
    req1 = 1'b1; len1 = 4'd4;
    model_burst(4);
    collect();
    n_cmp++;
    if (obs_timeout || obs_gid !== 1 || obs_gnt_wait !== 1 || obs_data.size() !== 4) begin
      n_bad++;
      $display("FAIL rstmid_next: got gid=%0d wait=%0d words=%0d expected gid=1 wait=1 words=4", obs_gid, obs_gnt_wait, obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 3) || obs_id[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL rstmid_word%0d: got data=%b last=%b expected data=%b last=%b", i, obs_data[i], obs_last[i], exp_data[i], (i == 3));
      end
    end
    m_last = 1'b1;
  endtask

  task automatic test_back_to_back();
    ready_mode = 1;
    for (int k = 0; k < 10; k++) begin
      logic g;
      int   n;
      if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; len0 = LW'($urandom); end
      if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; len1 = LW'($urandom); end
      if (!req0 && !req1) begin req0 = 1'b1; len0 = LW'($urandom); end
      if (req0) len0 = LW'($urandom);
      g = model_winner(req0, req1);
      n = model_len(g ? len1 : len0);
      model_burst(n);
      collect();
      n_cmp++;
      if (obs_timeout || obs_gid !== int'(g) || obs_gnt_wait !== 1 || obs_hold_err !== 0 || obs_proto_err !== 0) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: got gid=%0d wait=%0d hold=%0d proto=%0d to=%0d expected gid=%0d wait=1",
                 k, obs_gid, obs_gnt_wait, obs_hold_err, obs_proto_err, obs_timeout, g);
      end
      n_cmp++;
      if (obs_data.size() !== n) begin
        n_bad++;
        $display("FAIL b2b_count%0d: got %0d words expected %0d", k, obs_data.size(), n);
      end
      for (int i = 0; i < n && i < obs_data.size(); i++) begin
        n_cmp++;
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == n - 1) || obs_id[i] !== g) begin
          n_bad++;
          $display("FAIL b2b%0d_word%0d: got data=%b last=%b id=%b expected data=%b last=%b id=%b",
                   k, i, obs_data[i], obs_last[i], obs_id[i], exp_data[i], (i == n - 1), g);
        end
      end
      m_last = g;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_zero_seed();
    logic [W-1:0] first_exp;
`ifdef LFSR_CTRL_ZERO_GUARD_EN
    first_exp = SEED;
`else
    first_exp = '0;
`endif
    tick();
    seed_we = 1'b1; seed_in = '0;
    tick();
    seed_we = 1'b0;
    m_state = model_seed('0);
    ready_mode = 0;
    req0 = 1'b1; len0 = 4'd3;
    model_burst(3);
    collect();
    n_cmp++;
    if (obs_timeout || obs_data.size() !== 3) begin
      n_bad++;
      $display("FAIL zero_count: got %0d words expected 3", obs_data.size());
    end else begin
      n_cmp++;
      if (obs_data[0] !== first_exp) begin
        n_bad++;
        $display("FAIL zero_first: got %b expected %b", obs_data[0], first_exp);
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 2)) begin
          n_bad++;
          $display("FAIL zero_word%0d: got data=%b last=%b expected data=%b last=%b", i, obs_data[i], obs_last[i], exp_data[i], (i == 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_stall();
    test_seed();
    test_reset_mid();
    test_back_to_back();
    test_zero_seed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
